// File: rtl/loader_pkg.sv
// Shared constants for the data loader: word layout and default staging-FIFO geometry.
package loader_pkg;

    function automatic int clog2(input int value);
        int bits;
        bits = 0;
        while ((1 << bits) < value) bits++;
        return bits;
    endfunction

    localparam int LOADER_ADDR_BITS = 28;
    localparam int FIFO_WIDTH       = 36;
    localparam int LOADER_DATA_BITS = FIFO_WIDTH - LOADER_ADDR_BITS;
    localparam int FIFO_DEPTH       = 4;
    localparam int FIFO_WIDTHU      = clog2(FIFO_DEPTH);

endpackage

// File: rtl/loader_fifo_ram.sv
// Simple dual-port register array: one write port, one registered read port.
module loader_fifo_ram
    import loader_pkg::*;
#(
    parameter int WIDTH = FIFO_WIDTH,
    parameter int AW    = FIFO_WIDTHU
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [2**AW];

    // NOTE: the storage array is deliberately not reset; only pointers and q are.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // A same-edge write to raddr is not visible here: the read returns the old word.
    always_ff @(posedge clk) begin
        if (reset)   rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/loader_word_fifo.sv
// Single-clock staging FIFO between bridge-write capture and the memory write sequencer.
module loader_word_fifo
    import loader_pkg::*;
#(
    parameter int LPM_WIDTH    = FIFO_WIDTH,
    parameter int LPM_NUMWORDS = FIFO_DEPTH,
    parameter int LPM_WIDTHU   = FIFO_WIDTHU
) (
    input  logic                  clk_memory,
    input  logic                  reset,
    input  logic [LPM_WIDTH-1:0]  data,
    input  logic                  wrreq,
    input  logic                  rdreq,
    output logic [LPM_WIDTH-1:0]  q,
    output logic                  empty,
    output logic                  full,
    output logic [LPM_WIDTHU-1:0] usedw
);

    if (2**LPM_WIDTHU != LPM_NUMWORDS || LPM_NUMWORDS < 2) begin : g_bad_depth
        $error("loader_word_fifo: LPM_NUMWORDS must be a power of two >= 2 equal to 2**LPM_WIDTHU");
    end

    localparam int PW = LPM_WIDTHU + 1;
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic          wr_ok;
    logic          rd_ok;

    assign empty = (wptr == rptr);
    assign full  = (wptr[LPM_WIDTHU-1:0] == rptr[LPM_WIDTHU-1:0]) && (wptr[LPM_WIDTHU] != rptr[LPM_WIDTHU]);
    assign usedw = wptr[LPM_WIDTHU-1:0] - rptr[LPM_WIDTHU-1:0];

    assign rd_ok = rdreq & ~empty;
    assign wr_ok = wrreq & (~full | rd_ok);

    always_ff @(posedge clk_memory) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_ok) wptr <= wptr + PTR_ONE;
            if (rd_ok) rptr <= rptr + PTR_ONE;
        end
    end

    loader_fifo_ram #(
        .WIDTH (LPM_WIDTH),
        .AW    (LPM_WIDTHU)
    ) u_ram (
        .clk   (clk_memory),
        .reset (reset),
        .we    (wr_ok),
        .waddr (wptr[LPM_WIDTHU-1:0]),
        .wdata (data),
        .re    (rd_ok),
        .raddr (rptr[LPM_WIDTHU-1:0]),
        .rdata (q)
    );

endmodule

// File: tb/tb_loader_word_fifo.sv
// Self-checking bench for loader_word_fifo: directed scenarios plus randomized traffic vs a queue model.
module tb_loader_word_fifo;

    localparam int W     = 36;
    localparam int DEPTH = 4;
    localparam int WU    = 2;

    logic          clk_memory = 1'b0;
    logic          reset = 1'b1;
    logic [W-1:0]  data = '0;
    logic          wrreq = 1'b0;
    logic          rdreq = 1'b0;
    logic [W-1:0]  q;
    logic          empty;
    logic          full;
    logic [WU-1:0] usedw;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: a plain queue of stored words plus the last value read out.
    logic [W-1:0] fifo_m [$];
    logic [W-1:0] model_q = '0;

    loader_word_fifo #(
        .LPM_WIDTH    (W),
        .LPM_NUMWORDS (DEPTH),
        .LPM_WIDTHU   (WU)
    ) dut (
        .clk_memory (clk_memory),
        .reset      (reset),
        .data       (data),
        .wrreq      (wrreq),
        .rdreq      (rdreq),
        .q          (q),
        .empty      (empty),
        .full       (full),
        .usedw      (usedw)
    );

    always #5 clk_memory = ~clk_memory;

    // Drive one cycle of inputs, advance the model across the edge, sample #1 later.
    task automatic step(input logic r, input logic wr, input logic [W-1:0] d, input logic rd);
        logic rd_ok;
        logic wr_ok;
        reset = r;
        wrreq = wr;
        data  = d;
        rdreq = rd;
        @(posedge clk_memory);
        if (r) begin
            fifo_m.delete();
            model_q = '0;
        end else begin
            rd_ok = rd && (fifo_m.size() != 0);
            wr_ok = wr && ((fifo_m.size() < DEPTH) || rd_ok);
            if (rd_ok) model_q = fifo_m.pop_front();
            if (wr_ok) fifo_m.push_back(d);
        end
        #1;
        reset = 1'b0;
        wrreq = 1'b0;
        rdreq = 1'b0;
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);
        n_tests++;
        if (q !== '0 || empty !== 1'b1 || full !== 1'b0 || usedw !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_state: q=%h empty=%b full=%b usedw=%0d, want q=0 empty=1 full=0 usedw=0",
                     q, empty, full, usedw);
        end
        step(1'b0, 1'b0, '0, 1'b1);
        n_tests++;
        if (q !== '0 || empty !== 1'b1 || usedw !== 2'd0) begin
            n_fail++;
            $display("FAIL read_when_empty: q=%h empty=%b usedw=%0d, want q=0 empty=1 usedw=0", q, empty, usedw);
        end
    endtask

    task automatic test_single();
        step(1'b0, 1'b1, 36'h1_0000_0000, 1'b0);
        n_tests++;
        if (empty !== 1'b0 || usedw !== 2'd1) begin
            n_fail++;
            $display("FAIL single_write_flags: empty=%b usedw=%0d, want empty=0 usedw=1", empty, usedw);
        end
        step(1'b0, 1'b0, '0, 1'b1);
        n_tests++;
        if (q !== 36'h1_0000_0000 || empty !== 1'b1) begin
            n_fail++;
            $display("FAIL single_read: q=%h empty=%b, want q=100000000 empty=1", q, empty);
        end
    endtask

    task automatic test_fill_overflow();
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 36'hA1 + 36'(i), 1'b0);
        n_tests++;
        if (full !== 1'b1 || usedw !== 2'd0 || empty !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_flags: full=%b usedw=%0d empty=%b, want full=1 usedw=0 empty=0", full, usedw, empty);
        end
        step(1'b0, 1'b1, 36'hA5, 1'b0);
        n_tests++;
        if (full !== 1'b1 || usedw !== 2'd0) begin
            n_fail++;
            $display("FAIL overflow_ignored: full=%b usedw=%0d, want full=1 usedw=0", full, usedw);
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, '0, 1'b1);
            n_tests++;
            if (q !== 36'hA1 + 36'(i)) begin
                n_fail++;
                $display("FAIL drain_order[%0d]: q=%h, want %h", i, q, 36'hA1 + 36'(i));
            end
        end
        n_tests++;
        if (empty !== 1'b1 || full !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_empty: empty=%b full=%b, want empty=1 full=0", empty, full);
        end
        step(1'b0, 1'b0, '0, 1'b1);
        n_tests++;
        if (q !== 36'hA4) begin
            n_fail++;
            $display("FAIL q_hold_on_empty_read: q=%h, want a4", q);
        end
    endtask

    task automatic test_full_simul();
        logic [W-1:0] exp_words [4];
        exp_words = '{36'hB2, 36'hB3, 36'hB4, 36'hB5};
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 36'hB1 + 36'(i), 1'b0);
        step(1'b0, 1'b1, 36'hB5, 1'b1);
        n_tests++;
        if (q !== 36'hB1 || full !== 1'b1 || usedw !== 2'd0) begin
            n_fail++;
            $display("FAIL full_rw_same_cycle: q=%h full=%b usedw=%0d, want q=b1 full=1 usedw=0", q, full, usedw);
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, '0, 1'b1);
            n_tests++;
            if (q !== exp_words[i]) begin
                n_fail++;
                $display("FAIL full_rw_drain[%0d]: q=%h, want %h", i, q, exp_words[i]);
            end
        end
        n_tests++;
        if (empty !== 1'b1) begin
            n_fail++;
            $display("FAIL full_rw_empty: empty=%b, want 1", empty);
        end
    endtask

    task automatic test_empty_simul();
        step(1'b0, 1'b1, 36'hC1, 1'b1);
        n_tests++;
        if (q !== 36'hB5 || usedw !== 2'd1 || empty !== 1'b0) begin
            n_fail++;
            $display("FAIL empty_rw_same_cycle: q=%h usedw=%0d empty=%b, want q=b5 usedw=1 empty=0", q, usedw, empty);
        end
        step(1'b0, 1'b0, '0, 1'b1);
        n_tests++;
        if (q !== 36'hC1 || empty !== 1'b1) begin
            n_fail++;
            $display("FAIL empty_rw_followup: q=%h empty=%b, want q=c1 empty=1", q, empty);
        end
    endtask

    task automatic test_reset_mid();
        step(1'b0, 1'b1, 36'hD1, 1'b0);
        step(1'b0, 1'b1, 36'hD2, 1'b0);
        step(1'b1, 1'b1, 36'hDF, 1'b1);
        n_tests++;
        if (empty !== 1'b1 || usedw !== 2'd0 || full !== 1'b0 || q !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: empty=%b usedw=%0d full=%b q=%h, want empty=1 usedw=0 full=0 q=0",
                     empty, usedw, full, q);
        end
        step(1'b0, 1'b0, '0, 1'b1);
        n_tests++;
        if (q !== '0 || empty !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_read_ignored: q=%h empty=%b, want q=0 empty=1", q, empty);
        end
        step(1'b0, 1'b1, 36'hE1, 1'b0);
        step(1'b0, 1'b0, '0, 1'b1);
        n_tests++;
        if (q !== 36'hE1 || empty !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_reuse: q=%h empty=%b, want q=e1 empty=1", q, empty);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] rnd_data;
        logic         exp_empty;
        logic         exp_full;
        logic [WU-1:0] exp_usedw;
        for (int i = 0; i < 600; i++) begin
            rnd_data = {4'($urandom), $urandom};
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 99) < 55), rnd_data,
                 ($urandom_range(0, 99) < 45));
            exp_empty = (fifo_m.size() == 0);
            exp_full  = (fifo_m.size() == DEPTH);
            exp_usedw = WU'(fifo_m.size() % DEPTH);
            n_tests++;
            if (q !== model_q || empty !== exp_empty || full !== exp_full || usedw !== exp_usedw) begin
                n_fail++;
                $display("FAIL random[%0d]: q=%h empty=%b full=%b usedw=%0d, want q=%h empty=%b full=%b usedw=%0d",
                         i, q, empty, full, usedw, model_q, exp_empty, exp_full, exp_usedw);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_overflow();
        test_full_simul();
        test_empty_simul();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
